systolic_array_stream: RTL and testbench
========================================

# systolic_array_stream

Parameterised output-stationary ROWS x COLS systolic matrix-multiply engine with streaming valid/ready operand input, internal input skewing, variable K depth, saturating accumulators, cross-tile accumulate mode, and row-serial valid/ready result drain. It sits between the operand buffers and the result writeback path. It computes C(+)= A x B one K-tile per operation.

## Interface
- ROWS, 8: PE rows, which is also the number of A elements per beat and result rows (>=1).
- COLS, 8: PE columns, which is also the number of B elements per beat and results per drain beat (>=1).
- DATA_W, 8: signed operand width.
- ACC_W, 24: signed accumulator width; must be >= 2*DATA_W.
- CNT_W, 16: width of k_len and cycle_count.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- accumulate  in  1  sampled with start; 1 keeps the accumulators, 0 clears them.
- k_len  in  CNT_W  number of K beats; sampled with start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high exactly when state is FEED.
- a_in  in  ROWS x DATA_W  signed column k of A; element i feeds PE row i.
- b_in  in  COLS x DATA_W  signed row k of B; element j feeds PE column j.
- out_valid  out  1  result row valid; high exactly when state is DRAIN.
- out_ready  in  1  result sink ready.
- out_row_idx  out  $clog2(ROWS) (min 1)  index of the row currently presented.
- out_data  out  COLS x ACC_W  accumulators of row out_row_idx.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse, asserted in the cycle after the final drain handshake.
- sat_flag  out  1  sticky; set if any accumulator clamped during the operation.
- cycle_count  out  CNT_W  count of non-IDLE cycles in the current or last operation.

## Operation
- State IDLE:
  - When start=1, the engine latches k_len and accumulate, clears sat_flag and cycle_count, and clears all accumulators if accumulate=0.
  - Next state is FEED if k_len>0, otherwise DRAIN.
- State FEED:
  - A beat is accepted when in_valid && in_ready.
  - An accepted beat drives a_in/b_in into the skew stage. If no beat is accepted, zeros are injected (a bubble), and the array still shifts.
  - When the k_len-th beat is accepted, the next state is FLUSH. If ROWS+COLS-2 = 0, the next state is DRAIN instead.
- State FLUSH:
  - Zeros are injected for exactly ROWS+COLS-2 cycles, then the state moves to DRAIN.
- Skew stage:
  - Row i input passes through i register stages. Column j input passes through j register stages.
  - Each PE registers a to its right neighbour and b to the PE below.
  - PE(i,j) accumulates the product of the beat accepted in cycle t at the clock edge ending cycle t+i+j.
- Arithmetic:
  - The product is full precision (2*DATA_W) and sign-extended.
  - The sum is formed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A clamp sets sat_flag.
- State DRAIN:
  - out_data = accumulators of row out_row_idx. out_row_idx starts at 0.
  - On each handshake, out_row_idx increments. The handshake on row ROWS-1 moves the state to IDLE, pulses done, and resets out_row_idx to 0.
  - Accumulators keep their values after the drain, so a later start with accumulate=1 continues from them.
- start while busy is ignored.
- cycle_count increments every FEED/FLUSH/DRAIN cycle, saturates at all-ones, and holds in IDLE.

## Timing
- Reset (asynchronous, whenever reset_n=0, including mid-operation):
  - State goes to IDLE. All accumulators, skew and PE registers, counters and sat_flag are cleared.
  - Output values during and after reset: in_ready=0, out_valid=0, out_row_idx=0, out_data=0, busy=0, done=0, sat_flag=0, cycle_count=0.
  - Operation resumes only on a new start.
- No-stall latency: start sampled at edge 0, then k_len FEED cycles, then ROWS+COLS-2 FLUSH cycles, then ROWS DRAIN cycles, then done.
- out_data and out_row_idx stay stable while out_valid && !out_ready.
- Input stalls (in_valid=0) only insert bubbles; the numeric result is unchanged.
- in_ready has no combinational dependence on in_valid. out_valid has no combinational dependence on out_ready.

## Test plan
- Identity, ROWS=COLS=4, DATA_W=8, ACC_W=24, k_len=4: stimulus is A=I and B[k][j]=4k+j+1, stalls off, out_ready=1. Required: drain rows equal B rows (row 2 = 9,10,11,12), sat_flag=0.
- Accumulate: repeat the identity run with accumulate=1. Required: row 2 = 18,20,22,24. Then run with accumulate=0. Required: row 2 = 9,10,11,12 again.
- Saturation, ROWS=COLS=2, ACC_W=16, k_len=3, all operands -128: each product is 16384, and the 49152 total clamps. Required: all outputs 32767, sat_flag=1 until the next start.
- Backpressure, 8x8, random data:
  - Stimulus: in_valid random at 50%; out_ready held low for 5 cycles per row.
  - Required: results match a reference multiply, and out_data is held stable during stalls.
- Cycle timing, 8x8, k_len=8, no stalls:
  - Required in_ready high cycles 1-8, FLUSH cycles 9-22, and out_valid high cycles 23-30.
  - Required done pulse in cycle 31 and cycle_count=30.
- Boundaries:
  - k_len=0: straight to DRAIN with the previous accumulator values (or zeros if accumulate=0).
  - start during FEED: ignored.
  - reset_n pulsed low mid-FLUSH: all outputs are 0 immediately, and a fresh run gives correct results.

Source files
------------

// File: rtl/systolic_array_stream.sv
// systolic_array_stream: output-stationary ROWS x COLS matrix-multiply engine with skewed streaming input,
// saturating accumulators and row-serial valid/ready drain
module systolic_array_stream #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   accumulate,
    input  logic [CNT_W-1:0]       k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] a_in,
    input  logic [COLS*DATA_W-1:0] b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RW-1:0]          out_row_idx,
    output logic [COLS*ACC_W-1:0]  out_data,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag,
    output logic [CNT_W-1:0]       cycle_count
);
    localparam int SKEW = ROWS + COLS - 2;
    localparam int FL_W = $clog2(ROWS + COLS);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(SKEW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    state_t state;
    logic [CNT_W-1:0] k_len_q, k_cnt;
    logic [FL_W-1:0] fl_cnt;
    logic en, accept, clr;
    logic [ROWS*COLS-1:0] sat;
    logic signed [DATA_W-1:0] a_edge [ROWS];
    logic signed [DATA_W-1:0] b_edge [COLS];
    logic signed [DATA_W-1:0] a_q [ROWS][COLS];
    logic signed [DATA_W-1:0] b_q [ROWS][COLS];
    logic signed [ACC_W-1:0] acc [ROWS][COLS];

    assign in_ready = state == FEED;
    assign out_valid = state == DRAIN;
    assign busy = state != IDLE;
    assign en = state == FEED || state == FLUSH;
    assign accept = in_valid && in_ready;
    assign clr = state == IDLE && start && !accumulate;

    // row i is delayed by i stages so its operands meet column j's at PE(i,j) in step
    for (genvar i = 0; i < ROWS; i++) begin : g_ska
        logic signed [DATA_W-1:0] inj;
        assign inj = accept ? a_in[i*DATA_W +: DATA_W] : '0;
        if (i == 0) begin : g_d
            assign a_edge[i] = inj;
        end else begin : g_d
            logic signed [DATA_W-1:0] d [i];
            always_ff @(posedge clock or negedge reset_n)
                if (!reset_n) begin
                    for (int s = 0; s < i; s++) d[s] <= '0;
                end else if (en) begin
                    d[0] <= inj;
                    for (int s = 1; s < i; s++) d[s] <= d[s-1];
                end
            assign a_edge[i] = d[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_skb
        logic signed [DATA_W-1:0] inj;
        assign inj = accept ? b_in[j*DATA_W +: DATA_W] : '0;
        if (j == 0) begin : g_d
            assign b_edge[j] = inj;
        end else begin : g_d
            logic signed [DATA_W-1:0] d [j];
            always_ff @(posedge clock or negedge reset_n)
                if (!reset_n) begin
                    for (int s = 0; s < j; s++) d[s] <= '0;
                end else if (en) begin
                    d[0] <= inj;
                    for (int s = 1; s < j; s++) d[s] <= d[s-1];
                end
            assign b_edge[j] = d[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [DATA_W-1:0] av, bv;
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W:0] sum;
            logic ovf;
            if (j == 0) begin : g_a
                assign av = a_edge[i];
            end else begin : g_a
                assign av = a_q[i][j-1];
            end
            if (i == 0) begin : g_b
                assign bv = b_edge[j];
            end else begin : g_b
                assign bv = b_q[i-1][j];
            end
            assign prod = av * bv;
            assign sum = {acc[i][j][ACC_W-1], acc[i][j]} + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
            assign sat[i*COLS+j] = en && ovf;
            always_ff @(posedge clock or negedge reset_n)
                if (!reset_n) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                    acc[i][j] <= '0;
                end else begin
                    if (en) begin
                        a_q[i][j] <= av;
                        b_q[i][j] <= bv;
                    end
                    if (clr)
                        acc[i][j] <= '0;
                    else if (en)
                        acc[i][j] <= ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
                end
        end
    end

    always_comb
        for (int j = 0; j < COLS; j++) out_data[j*ACC_W +: ACC_W] = acc[out_row_idx][j];

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            k_len_q <= '0;
            k_cnt <= '0;
            fl_cnt <= '0;
            out_row_idx <= '0;
            done <= 1'b0;
            sat_flag <= 1'b0;
            cycle_count <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (en && |sat) sat_flag <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    k_len_q <= k_len;
                    k_cnt <= '0;
                    fl_cnt <= '0;
                    sat_flag <= 1'b0;
                    cycle_count <= '0;
                    state <= k_len != '0 ? FEED : DRAIN;
                end
                FEED: if (in_valid) begin
                    k_cnt <= k_cnt + 1'b1;
                    if (k_cnt == k_len_q - 1'b1) state <= SKEW == 0 ? DRAIN : FLUSH;
                end
                FLUSH: begin
                    fl_cnt <= fl_cnt + 1'b1;
                    if (fl_cnt == FL_LAST) state <= DRAIN;
                end
                DRAIN: if (out_ready) begin
                    out_row_idx <= out_row_idx == ROW_LAST ? '0 : out_row_idx + 1'b1;
                    if (out_row_idx == ROW_LAST) begin
                        state <= IDLE;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_systolic_array_stream.sv
// tb_systolic_array_stream: directed checks of a 4x4, a saturating 2x2 and an 8x8 engine
module tb_systolic_array_stream;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic start4 = 0, acc4 = 0, in_valid4 = 0, out_ready4 = 1;
    logic [15:0] klen4 = 0;
    logic [31:0] a4 = 0, b4 = 0;
    logic in_ready4, out_valid4, busy4, done4, sat4;
    logic [1:0] row4;
    logic [95:0] od4;
    logic [15:0] cc4;

    logic start2 = 0, acc2 = 0, in_valid2 = 0, out_ready2 = 1;
    logic [15:0] klen2 = 0;
    logic [15:0] a2 = 0, b2 = 0;
    logic in_ready2, out_valid2, busy2, done2, sat2;
    logic [0:0] row2;
    logic [31:0] od2;
    logic [15:0] cc2;

    logic start8 = 0, acc8 = 0, in_valid8 = 0, out_ready8 = 1;
    logic [15:0] klen8 = 0;
    logic [63:0] a8 = 0, b8 = 0;
    logic in_ready8, out_valid8, busy8, done8, sat8;
    logic [2:0] row8;
    logic [191:0] od8;
    logic [15:0] cc8;

    systolic_array_stream #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(24), .CNT_W(16)) u4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .accumulate(acc4), .k_len(klen4),
        .in_valid(in_valid4), .in_ready(in_ready4), .a_in(a4), .b_in(b4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_row_idx(row4), .out_data(od4), .busy(busy4), .done(done4),
        .sat_flag(sat4), .cycle_count(cc4));

    systolic_array_stream #(.ROWS(2), .COLS(2), .DATA_W(8), .ACC_W(16), .CNT_W(16)) u2 (
        .clock(clock), .reset_n(reset_n), .start(start2), .accumulate(acc2), .k_len(klen2),
        .in_valid(in_valid2), .in_ready(in_ready2), .a_in(a2), .b_in(b2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_row_idx(row2), .out_data(od2), .busy(busy2), .done(done2),
        .sat_flag(sat2), .cycle_count(cc2));

    systolic_array_stream #(.ROWS(8), .COLS(8), .DATA_W(8), .ACC_W(24), .CNT_W(16)) u8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .accumulate(acc8), .k_len(klen8),
        .in_valid(in_valid8), .in_ready(in_ready8), .a_in(a8), .b_in(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_row_idx(row8), .out_data(od8), .busy(busy8), .done(done8),
        .sat_flag(sat8), .cycle_count(cc8));

    int n_cmp = 0, n_bad = 0;
    int res4 [4][4];
    int res2 [2][2];
    longint res8 [8][8];
    longint ref8 [8][8];
    int ma [8][16];
    int mb [16][8];

    typedef struct {
        logic acc;
        int k;
        int scale;
        logic stall;
        logic poke;
        int mul;
        int row2 [4];
        int cyc;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // 4x4: A = scale*I, B[k][j] = 4k+j+1; poke raises start (accumulate=0) mid-FEED
    task automatic run4(input logic acc, input int k, input int scale, input logic stall, input logic poke);
        int beat, rows, cyc;
        start4 = 1; acc4 = acc; klen4 = 16'(k);
        @(negedge clock);
        start4 = 0; acc4 = 0; klen4 = 16'd1;
        beat = 0; rows = 0; cyc = 0;
        while (rows < 4 && cyc < 300) begin
            in_valid4 = beat < k && (!stall || $urandom_range(1) == 1);
            for (int r = 0; r < 4; r++) a4[r*8 +: 8] = 8'(r == beat ? scale : 0);
            for (int c = 0; c < 4; c++) b4[c*8 +: 8] = 8'(4 * beat + c + 1);
            start4 = poke && beat == 1;
            if (out_valid4 && out_ready4) begin
                for (int c = 0; c < 4; c++) res4[row4][c] = $signed(od4[c*24 +: 24]);
                rows++;
            end
            if (in_valid4 && in_ready4) beat++;
            @(negedge clock);
            cyc++;
        end
        start4 = 0; in_valid4 = 0;
        chk("run4_rows_drained", rows, 4);
    endtask

    task automatic run8(input int k, input logic bp, input logic timing);
        int beat, rows, cyc, hold;
        logic [191:0] held;
        logic [2:0] held_idx;
        for (int r = 0; r < 8; r++)
            for (int q = 0; q < k; q++) ma[r][q] = int'($urandom_range(255)) - 128;
        for (int q = 0; q < k; q++)
            for (int c = 0; c < 8; c++) mb[q][c] = int'($urandom_range(255)) - 128;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                ref8[r][c] = 0;
                for (int q = 0; q < k; q++) ref8[r][c] += longint'(ma[r][q] * mb[q][c]);
            end
        start8 = 1; acc8 = 0; klen8 = 16'(k);
        @(negedge clock);
        start8 = 0;
        beat = 0; rows = 0; cyc = 1; hold = 0; held = '0; held_idx = '0;
        while (rows < 8 && cyc < 800) begin
            in_valid8 = beat < k && (!bp || $urandom_range(1) == 1);
            for (int r = 0; r < 8; r++) a8[r*8 +: 8] = beat < k ? 8'(ma[r][beat]) : 8'd0;
            for (int c = 0; c < 8; c++) b8[c*8 +: 8] = beat < k ? 8'(mb[beat][c]) : 8'd0;
            out_ready8 = !bp || hold == 5;
            if (timing) begin
                chk($sformatf("in_ready_c%0d", cyc), longint'(in_ready8), longint'(cyc >= 1 && cyc <= 8));
                chk($sformatf("out_valid_c%0d", cyc), longint'(out_valid8), longint'(cyc >= 23 && cyc <= 30));
                chk($sformatf("done_c%0d", cyc), longint'(done8), 0);
            end
            if (out_valid8) begin
                if (hold > 0) begin
                    chk("stall_row_idx", longint'(row8), longint'(held_idx));
                    for (int c = 0; c < 8; c++)
                        chk("stall_data", $signed(od8[c*24 +: 24]), $signed(held[c*24 +: 24]));
                end
                held = od8; held_idx = row8;
                if (out_ready8) begin
                    for (int c = 0; c < 8; c++) res8[row8][c] = $signed(od8[c*24 +: 24]);
                    rows++;
                    hold = 0;
                end else hold++;
            end
            if (in_valid8 && in_ready8) beat++;
            @(negedge clock);
            cyc++;
        end
        in_valid8 = 0; out_ready8 = 1;
        chk("run8_rows_drained", rows, 8);
        chk("run8_done", longint'(done8), 1);
        if (timing) begin
            chk("run8_done_cycle", cyc, 31);
            chk("run8_cycle_count", longint'(cc8), 30);
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) chk($sformatf("run8_c%0d%0d", r, c), res8[r][c], ref8[r][c]);
    endtask

    initial begin
        int rows, cyc;
        tbl[0] = '{1'b0, 4, 1, 1'b0, 1'b0, 1, '{9, 10, 11, 12}, 14};
        tbl[1] = '{1'b1, 4, 1, 1'b0, 1'b0, 2, '{18, 20, 22, 24}, 14};
        tbl[2] = '{1'b0, 4, 1, 1'b0, 1'b0, 1, '{9, 10, 11, 12}, 14};
        tbl[3] = '{1'b1, 0, 1, 1'b0, 1'b0, 1, '{9, 10, 11, 12}, 4};
        tbl[4] = '{1'b0, 0, 1, 1'b0, 1'b0, 0, '{0, 0, 0, 0}, 4};
        tbl[5] = '{1'b0, 4, -1, 1'b1, 1'b0, -1, '{-9, -10, -11, -12}, -1};
        tbl[6] = '{1'b1, 4, 3, 1'b0, 1'b1, 2, '{18, 20, 22, 24}, 14};
        tbl[7] = '{1'b0, 4, 2, 1'b1, 1'b1, 2, '{18, 20, 22, 24}, -1};

        repeat (3) @(negedge clock);
        chk("rst_in_ready", longint'(in_ready4), 0);
        chk("rst_out_valid", longint'(out_valid4), 0);
        chk("rst_row_idx", longint'(row4), 0);
        chk("rst_out_data_any", longint'(|od4), 0);
        chk("rst_busy", longint'(busy4), 0);
        chk("rst_done", longint'(done4), 0);
        chk("rst_cycle_count", longint'(cc4), 0);
        reset_n = 1;
        @(negedge clock);

        for (int v = 0; v < 8; v++) begin
            run4(tbl[v].acc, tbl[v].k, tbl[v].scale, tbl[v].stall, tbl[v].poke);
            chk($sformatf("v%0d_done", v), longint'(done4), 1);
            chk($sformatf("v%0d_busy", v), longint'(busy4), 0);
            chk($sformatf("v%0d_sat", v), longint'(sat4), 0);
            if (tbl[v].cyc >= 0) chk($sformatf("v%0d_cycle_count", v), longint'(cc4), tbl[v].cyc);
            for (int c = 0; c < 4; c++) chk($sformatf("v%0d_row2_c%0d", v, c), res4[2][c], tbl[v].row2[c]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    chk($sformatf("v%0d_r%0dc%0d", v, r, c), res4[r][c], tbl[v].mul * (4 * r + c + 1));
            @(negedge clock);
            chk($sformatf("v%0d_done_pulse_end", v), longint'(done4), 0);
        end

        // saturation: three products of 16384 clamp a 16-bit accumulator
        start2 = 1; acc2 = 0; klen2 = 16'd3; a2 = 16'h8080; b2 = 16'h8080;
        @(negedge clock);
        start2 = 0; in_valid2 = 1; rows = 0; cyc = 0;
        while (rows < 2 && cyc < 100) begin
            if (out_valid2) begin
                for (int c = 0; c < 2; c++) res2[row2][c] = $signed(od2[c*16 +: 16]);
                rows++;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid2 = 0;
        chk("sat_rows_drained", rows, 2);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) chk($sformatf("sat_r%0dc%0d", r, c), res2[r][c], 32767);
        chk("sat_flag_set", longint'(sat2), 1);
        repeat (4) @(negedge clock);
        chk("sat_flag_sticky", longint'(sat2), 1);
        start2 = 1; acc2 = 1; klen2 = 16'd0;
        @(negedge clock);
        start2 = 0;
        chk("sat_flag_cleared", longint'(sat2), 0);
        chk("sat_k0_drain", longint'(out_valid2), 1);
        chk("sat_k0_keep", $signed(od2[15:0]), 32767);
        repeat (3) @(negedge clock);

        run8(8, 1'b0, 1'b1);
        @(negedge clock);
        run8(10, 1'b1, 1'b0);
        @(negedge clock);

        // reset pulsed in the middle of FLUSH
        start4 = 1; acc4 = 0; klen4 = 16'd4;
        @(negedge clock);
        start4 = 0; in_valid4 = 1;
        for (int q = 0; q < 4; q++) begin
            for (int r = 0; r < 4; r++) a4[r*8 +: 8] = 8'(r == q ? 1 : 0);
            for (int c = 0; c < 4; c++) b4[c*8 +: 8] = 8'(4 * q + c + 1);
            @(negedge clock);
        end
        in_valid4 = 0;
        repeat (2) @(negedge clock);
        chk("pre_reset_busy", longint'(busy4), 1);
        chk("pre_reset_row0", $signed(od4[23:0]), 1);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_in_ready", longint'(in_ready4), 0);
        chk("mid_rst_out_valid", longint'(out_valid4), 0);
        chk("mid_rst_row_idx", longint'(row4), 0);
        chk("mid_rst_out_data_any", longint'(|od4), 0);
        chk("mid_rst_busy", longint'(busy4), 0);
        chk("mid_rst_done", longint'(done4), 0);
        chk("mid_rst_sat", longint'(sat4), 0);
        chk("mid_rst_cycle_count", longint'(cc4), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        chk("post_rst_idle", longint'(busy4), 0);
        run4(1'b1, 4, 1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) chk($sformatf("post_rst_r%0dc%0d", r, c), res4[r][c], 4 * r + c + 1);
        chk("post_rst_cycle_count", longint'(cc4), 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
